// File: rtl/ase_emul_rob_pkg.sv
// ase_emul_rob_pkg: default sizes and shared types for the read-response reorder buffer.
package ase_emul_rob_pkg;
   localparam int DEF_DATA_WIDTH     = 512;
   localparam int DEF_RESPONSE_WIDTH = 2;
   localparam int DEF_USER_WIDTH     = 8;
   localparam int DEF_TAG_WIDTH      = 4;
   localparam int DEPTH              = 2 ** DEF_TAG_WIDTH;
   typedef logic [DEF_TAG_WIDTH-1:0] t_tag;
   typedef logic [DEF_TAG_WIDTH:0]   t_count;
   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0]     data;
      logic [DEF_RESPONSE_WIDTH-1:0] response;
      logic [DEF_USER_WIDTH-1:0]     user;
   } t_slot;
endpackage

// File: rtl/ase_emul_rob_ram.sv
// ase_emul_rob_ram: slot payload storage; data/response written on response accept,
// user written on allocation, registered read at the head slot.
module ase_emul_rob_ram #(
   parameter int DW = 512,
   parameter int RW = 2,
   parameter int UW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rsp_we_i,
   input  logic [AW-1:0] rsp_addr_i,
   input  logic [DW-1:0] rsp_data_i,
   input  logic [RW-1:0] rsp_response_i,
   input  logic          usr_we_i,
   input  logic [AW-1:0] usr_addr_i,
   input  logic [UW-1:0] usr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   output logic [RW-1:0] rd_response_o,
   output logic [UW-1:0] rd_user_o
);
   logic [DW-1:0] data_mem [2**AW];
   logic [RW-1:0] resp_mem [2**AW];
   logic [UW-1:0] user_mem [2**AW];
   always_ff @(posedge clk) begin
      if (rsp_we_i) begin
         data_mem[rsp_addr_i] <= rsp_data_i;
         resp_mem[rsp_addr_i] <= rsp_response_i;
      end
      if (usr_we_i) user_mem[usr_addr_i] <= usr_data_i;
      if (rd_en_i) begin
         rd_data_o     <= data_mem[rd_addr_i];
         rd_response_o <= resp_mem[rd_addr_i];
         rd_user_o     <= user_mem[rd_addr_i];
      end
   end
endmodule

// File: rtl/ase_emul_rsp_reorder_buf.sv
// ase_emul_rsp_reorder_buf: tags read requests at issue and releases out-of-order
// tagged responses strictly in allocation order, one per cycle.
module ase_emul_rsp_reorder_buf
   import ase_emul_rob_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int RESPONSE_WIDTH = DEF_RESPONSE_WIDTH,
   parameter int USER_WIDTH     = DEF_USER_WIDTH,
   parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_en,
   input  logic [USER_WIDTH-1:0]     alloc_user,
   output logic                      alloc_ready,
   output logic [TAG_WIDTH-1:0]      alloc_tag,
   input  logic                      rsp_valid,
   input  logic [TAG_WIDTH-1:0]      rsp_tag,
   input  logic [DATA_WIDTH-1:0]     rsp_data,
   input  logic [RESPONSE_WIDTH-1:0] rsp_response,
   output logic                      out_valid,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [RESPONSE_WIDTH-1:0] out_response,
   output logic [USER_WIDTH-1:0]     out_user,
   output logic                      err_tag
);
   localparam int SLOTS = 2 ** TAG_WIDTH;
   localparam logic [TAG_WIDTH:0] FULL = (TAG_WIDTH+1)'(SLOTS);
   logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [TAG_WIDTH:0]   count_q, count_d;
   logic [SLOTS-1:0]     alloc_vld_q, alloc_vld_d, filled_q, filled_d;
   logic                 err_q, err_d, out_valid_q;
   logic                 alloc_fire, rsp_ok, rel;
   assign alloc_ready = count_q != FULL;
   assign alloc_tag   = tail_q;
   assign out_valid   = out_valid_q;
   assign err_tag     = err_q;
   // Release looks only at registered filled[head], giving the fixed two-cycle latency.
   always_comb begin
      alloc_fire  = alloc_en & alloc_ready;
      rsp_ok      = rsp_valid & alloc_vld_q[rsp_tag] & ~filled_q[rsp_tag];
      rel         = filled_q[head_q];
      alloc_vld_d = alloc_vld_q;
      filled_d    = filled_q;
      if (alloc_fire) alloc_vld_d[tail_q] = 1'b1;
      if (rsp_ok) filled_d[rsp_tag] = 1'b1;
      if (rel) begin
         alloc_vld_d[head_q] = 1'b0;
         filled_d[head_q]    = 1'b0;
      end
      tail_d  = alloc_fire ? tail_q + TAG_WIDTH'(1) : tail_q;
      head_d  = rel ? head_q + TAG_WIDTH'(1) : head_q;
      count_d = (alloc_fire & ~rel) ? count_q + (TAG_WIDTH+1)'(1) :
                (~alloc_fire & rel) ? count_q - (TAG_WIDTH+1)'(1) : count_q;
      err_d   = err_q | (rsp_valid & ~rsp_ok);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         alloc_vld_q <= '0;
         filled_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         alloc_vld_q <= alloc_vld_d;
         filled_q    <= filled_d;
         err_q       <= err_d;
         out_valid_q <= rel;
      end
   end
   ase_emul_rob_ram #(
      .DW(DATA_WIDTH),
      .RW(RESPONSE_WIDTH),
      .UW(USER_WIDTH),
      .AW(TAG_WIDTH)
   ) u_ram (
      .clk            (clk),
      .rsp_we_i       (rsp_ok),
      .rsp_addr_i     (rsp_tag),
      .rsp_data_i     (rsp_data),
      .rsp_response_i (rsp_response),
      .usr_we_i       (alloc_fire),
      .usr_addr_i     (tail_q),
      .usr_data_i     (alloc_user),
      .rd_en_i        (rel),
      .rd_addr_i      (head_q),
      .rd_data_o      (out_data),
      .rd_response_o  (out_response),
      .rd_user_o      (out_user)
   );
endmodule

// File: tb/tb_ase_emul_rsp_reorder_buf.sv
// tb_ase_emul_rsp_reorder_buf: order/latency vectors, full/wrap, tag errors, reset
// mid-flight and a randomised out-of-order response stream against a scoreboard.
module tb_ase_emul_rsp_reorder_buf;
   import ase_emul_rob_pkg::*;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         alloc_en = 1'b0;
   logic [7:0]   alloc_user = '0;
   logic         alloc_ready;
   logic [3:0]   alloc_tag;
   logic         rsp_valid = 1'b0;
   logic [3:0]   rsp_tag = '0;
   logic [511:0] rsp_data = '0;
   logic [1:0]   rsp_response = '0;
   logic         out_valid;
   logic [511:0] out_data;
   logic [1:0]   out_response;
   logic [7:0]   out_user;
   logic         err_tag;

   ase_emul_rsp_reorder_buf dut (
      .clk(clk), .reset(reset),
      .alloc_en(alloc_en), .alloc_user(alloc_user), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_response(rsp_response),
      .out_valid(out_valid), .out_data(out_data), .out_response(out_response), .out_user(out_user),
      .err_tag(err_tag)
   );

   always #5 clk = ~clk;

   int    n_chk = 0, n_fail = 0, cyc = 0, n_out = 0, first_cyc = -1, last_cyc = -1;
   int    seq = 0;
   int    tag_seq [16];
   t_tag  m_tail = '0;
   t_tag  pend [$];
   t_slot sb [$];
   t_slot mon_e;

   typedef struct {
      int ord [4];
      int exp_first;
   } vec_t;
   vec_t vt [4];

   function automatic t_slot slot_of(int s);
      t_slot x;
      logic [31:0] w;
      w = s ^ 32'h5A5A_0000;
      x.data     = {16{w}};
      x.response = 2'(s);
      x.user     = 8'(s * 7 + 3);
      return x;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         n_out++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected out_valid: got user %0h resp %0h, expected no output", out_user, out_response);
         end else begin
            mon_e = sb.pop_front();
            if ({out_data, out_response, out_user} !== mon_e) begin
               n_fail++;
               $display("FAIL out order: got data %h resp %0h user %0h expected data %h resp %0h user %0h",
                        out_data, out_response, out_user, mon_e.data, mon_e.response, mon_e.user);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      alloc_en = 1'b0;
      rsp_valid = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
      m_tail = '0;
      sb.delete();
      pend.delete();
   endtask

   task automatic alloc_one();
      t_slot s;
      s = slot_of(seq);
      chk("alloc_ready", alloc_ready, 1);
      chk("alloc_tag", alloc_tag, m_tail);
      alloc_en = 1'b1;
      alloc_user = s.user;
      tag_seq[m_tail] = seq;
      sb.push_back(s);
      pend.push_back(m_tail);
      seq++;
      m_tail++;
      tick();
      alloc_en = 1'b0;
   endtask

   task automatic respond(t_tag t);
      t_slot s;
      s = slot_of(tag_seq[t]);
      rsp_valid = 1'b1;
      rsp_tag = t;
      rsp_data = s.data;
      rsp_response = s.response;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic respond_raw(t_tag t);
      rsp_valid = 1'b1;
      rsp_tag = t;
      rsp_data = {16{32'hDEAD_BEEF}};
      rsp_response = 2'b11;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
      tick();
      chk("drain remaining", sb.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      t_tag base, t;
      int   e0, allocs, guard, idx;
      vt[0] = '{ord: '{0, 1, 2, 3}, exp_first: 1};
      vt[1] = '{ord: '{3, 2, 1, 0}, exp_first: 4};
      vt[2] = '{ord: '{1, 0, 3, 2}, exp_first: 2};
      vt[3] = '{ord: '{2, 0, 1, 3}, exp_first: 2};
      do_reset(2);
      chk("reset alloc_ready", alloc_ready, 1);
      chk("reset alloc_tag", alloc_tag, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset err_tag", err_tag, 0);

      // Order / latency vectors.
      for (int v = 0; v < 4; v++) begin
         base = m_tail;
         repeat (4) alloc_one();
         pend.delete();
         n_out = 0;
         first_cyc = -1;
         e0 = 0;
         for (int k = 0; k < 4; k++) begin
            respond(t_tag'(base + t_tag'(vt[v].ord[k])));
            if (k == 0) e0 = cyc;
         end
         drain();
         chk("first out latency", 64'(first_cyc - e0), 64'(vt[v].exp_first));
         chk("burst span", 64'(last_cyc - first_cyc), 3);
         chk("out count", 64'(n_out), 4);
      end

      // Full, ignored alloc, release-one, wrap.
      repeat (16) alloc_one();
      chk("full alloc_ready", alloc_ready, 0);
      alloc_en = 1'b1;
      alloc_user = 8'hEE;
      tick();
      alloc_en = 1'b0;
      chk("ignored alloc tag", alloc_tag, m_tail);
      chk("ignored alloc ready", alloc_ready, 0);
      t = pend.pop_front();
      respond(t);
      chk("no early free", alloc_ready, 0);
      tick();
      chk("freed alloc_ready", alloc_ready, 1);
      chk("wrap alloc_tag", alloc_tag, 0);
      alloc_one();
      while (pend.size() != 0) respond(pend.pop_front());
      drain();
      for (int i = 0; i < 40; i++) begin
         alloc_one();
         respond(pend.pop_front());
      end
      drain();

      // Duplicate response to a filled slot.
      chk("pre-error err_tag", err_tag, 0);
      base = m_tail;
      repeat (4) alloc_one();
      pend.delete();
      respond(t_tag'(base + 2));
      chk("dup before err_tag", err_tag, 0);
      respond_raw(t_tag'(base + 2));
      chk("dup err_tag", err_tag, 1);
      respond(t_tag'(base + 0));
      respond(t_tag'(base + 1));
      respond(t_tag'(base + 3));
      drain();
      chk("err_tag sticky", err_tag, 1);

      // Never-allocated tag.
      do_reset(1);
      chk("reset clears err_tag", err_tag, 0);
      respond_raw(4'd5);
      chk("unalloc err_tag", err_tag, 1);
      repeat (3) tick();

      // Reset mid-flight.
      do_reset(1);
      repeat (6) alloc_one();
      do_reset(1);
      respond_raw(4'd1);
      repeat (4) tick();
      chk("late rsp err_tag", err_tag, 1);
      chk("post-reset alloc_tag", alloc_tag, 0);
      repeat (16) alloc_one();
      chk("count was zero", alloc_ready, 0);

      // Randomised out-of-order stream.
      do_reset(1);
      n_out = 0;
      allocs = 0;
      guard = 0;
      while ((allocs < 10000 || pend.size() != 0) && guard < 60000) begin
         guard++;
         if (allocs < 10000 && $urandom_range(0, 9) < 6 && alloc_ready) begin
            chk("rnd alloc_tag", alloc_tag, m_tail);
            alloc_en = 1'b1;
            alloc_user = slot_of(seq).user;
            tag_seq[m_tail] = seq;
            sb.push_back(slot_of(seq));
            pend.push_back(m_tail);
            seq++;
            m_tail++;
            allocs++;
         end
         if (pend.size() > 1 && $urandom_range(0, 9) < 6) begin
            idx = $urandom_range(0, pend.size() - 2);
            t = pend[idx];
            pend.delete(idx);
            rsp_valid = 1'b1;
            rsp_tag = t;
            rsp_data = slot_of(tag_seq[t]).data;
            rsp_response = slot_of(tag_seq[t]).response;
         end else if (pend.size() != 0 && !alloc_en && $urandom_range(0, 9) < 6) begin
            t = pend.pop_back();
            rsp_valid = 1'b1;
            rsp_tag = t;
            rsp_data = slot_of(tag_seq[t]).data;
            rsp_response = slot_of(tag_seq[t]).response;
         end
         tick();
         alloc_en = 1'b0;
         rsp_valid = 1'b0;
      end
      chk("random within budget", 64'(guard < 60000), 1);
      drain();
      chk("random err_tag", err_tag, 0);
      chk("random out count", 64'(n_out), 10000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
